// File: rtl/simpleadder_serial_pkg.sv
// Shared types and width helpers for the bit-serial adder.
package simpleadder_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        SEND = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 2;

    function automatic int res_width(input int w);
        return w + 1;
    endfunction

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/simpleadder_serial_shift_reg.sv
// Load/shift register; serial data enters at the LSB, the MSB of o_q
// is the serial output.
module serial_shift_reg #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic         i_sin,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_shift) begin
            r_q <= W'({r_q, i_sin});
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/simpleadder_serial.sv
// Bit-serial unsigned adder, operands and sum MSB first.
// SIMPLEADDER_SERIAL_BUSYERR_EN adds busy_err for strobes during a frame.
module simpleadder_serial
    import simpleadder_serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ina,
    input  logic inb,
    input  logic en_i,
`ifdef SIMPLEADDER_SERIAL_BUSYERR_EN
    output logic busy_err,
`endif
    output logic out,
    output logic en_o
);

    localparam int RW = res_width(WIDTH);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_RECV = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_SEND = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e r_state;
    state_e w_state_nxt;

    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_en_o;
    logic             w_en_o_nxt;
    logic             w_op_shift;
    logic             w_res_load;
    logic             w_res_shift;
    logic             w_recv_last;
    logic             w_send_last;
    logic [WIDTH-1:0] w_a_q;
    logic [WIDTH-1:0] w_b_q;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [RW-1:0]    w_sum;
    logic [RW-1:0]    w_res_q;

    // Operand values including the bit on the lines this cycle
    assign w_a_nxt = WIDTH'({w_a_q, ina});
    assign w_b_nxt = WIDTH'({w_b_q, inb});
    assign w_sum   = RW'(w_a_nxt) + RW'(w_b_nxt);

    assign w_recv_last = (r_cnt == CNT_ONE);
    assign w_send_last = (r_cnt == '0);

    serial_shift_reg #(.W(WIDTH)) u_op_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (1'b0),
        .i_shift (w_op_shift),
        .i_sin   (ina),
        .i_data  ('0),
        .o_q     (w_a_q)
    );

    serial_shift_reg #(.W(WIDTH)) u_op_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (1'b0),
        .i_shift (w_op_shift),
        .i_sin   (inb),
        .i_data  ('0),
        .o_q     (w_b_q)
    );

    serial_shift_reg #(.W(RW)) u_res (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_res_load),
        .i_shift (w_res_shift),
        .i_sin   (1'b0),
        .i_data  (w_sum),
        .o_q     (w_res_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (en_i) begin
                    w_state_nxt = (WIDTH == 1) ? SEND : RECV;
                end
            end
            RECV: begin
                if (w_recv_last) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_send_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_op_shift  = 1'b0;
        w_res_load  = 1'b0;
        w_res_shift = 1'b0;
        w_en_o_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (en_i) begin
                    w_op_shift = 1'b1;
                    if (WIDTH == 1) begin
                        w_res_load = 1'b1;
                        w_en_o_nxt = 1'b1;
                        w_cnt_nxt  = CNT_SEND;
                    end else begin
                        w_cnt_nxt  = CNT_RECV;
                    end
                end
            end
            RECV: begin
                w_op_shift = 1'b1;
                if (w_recv_last) begin
                    w_res_load = 1'b1;
                    w_en_o_nxt = 1'b1;
                    w_cnt_nxt  = CNT_SEND;
                end else begin
                    w_cnt_nxt  = r_cnt - CNT_ONE;
                end
            end
            SEND: begin
                // Zeros shift in behind the sum, so out idles at 0
                w_res_shift = 1'b1;
                if (!w_send_last) begin
                    w_en_o_nxt = 1'b1;
                    w_cnt_nxt  = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_en_o <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_en_o <= w_en_o_nxt;
        end
    end

    assign out  = w_res_q[RW-1];
    assign en_o = r_en_o;

`ifdef SIMPLEADDER_SERIAL_BUSYERR_EN
    logic r_busy_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_err <= 1'b0;
        end else begin
            r_busy_err <= en_i && (r_state != IDLE);
        end
    end

    assign busy_err = r_busy_err;
`endif

endmodule

// File: tb/tb_simpleadder_serial.sv
// Randomized bench for simpleadder_serial at WIDTH=2 and WIDTH=4,
// checked against a frame-level arithmetic model.
module tb_simpleadder_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic ina2 = 1'b0, inb2 = 1'b0, en2 = 1'b0;
    logic ina4 = 1'b0, inb4 = 1'b0, en4 = 1'b0;
    logic out2, eno2, out4, eno4;
`ifdef SIMPLEADDER_SERIAL_BUSYERR_EN
    logic busy2, busy4;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    simpleadder_serial #(.WIDTH(2)) u_dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .ina      (ina2),
        .inb      (inb2),
        .en_i     (en2),
`ifdef SIMPLEADDER_SERIAL_BUSYERR_EN
        .busy_err (busy2),
`endif
        .out      (out2),
        .en_o     (eno2)
    );

    simpleadder_serial #(.WIDTH(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .ina      (ina4),
        .inb      (inb4),
        .en_i     (en4),
`ifdef SIMPLEADDER_SERIAL_BUSYERR_EN
        .busy_err (busy4),
`endif
        .out      (out4),
        .en_o     (eno4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic get_out(input int sel);
        return (sel == 0) ? out2 : out4;
    endfunction

    function automatic logic get_eno(input int sel);
        return (sel == 0) ? eno2 : eno4;
    endfunction

`ifdef SIMPLEADDER_SERIAL_BUSYERR_EN
    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy2 : busy4;
    endfunction
`endif

    task automatic drive(input int sel, input logic e, input logic a,
                         input logic b);
        if (sel == 0) begin
            en2 = e; ina2 = a; inb2 = b;
        end else begin
            en4 = e; ina4 = a; inb4 = b;
        end
    endtask

    // Idle cycles: no output activity expected on either instance
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_eno2", eno2, 0);
            chk("idle_out2", out2, 0);
            chk("idle_eno4", eno4, 0);
            chk("idle_out4", out4, 0);
            drive(0, 1'b0, 1'($urandom), 1'($urandom));
            drive(1, 1'b0, 1'($urandom), 1'($urandom));
        end
    endtask

    // One frame: w operand cycles, then w+1 result cycles. stb is the
    // cycle index (1..2w-1) of an extra en_i pulse, or -1 for none.
    task automatic frame(input int sel, input int w, input int a,
                         input int b, input int stb);
        int s;
        logic e;
        logic exp_busy;
        s = a + b;
        exp_busy = 1'b0;
        for (int k = 0; k < w; k++) begin
            @(negedge clk);
            chk("rx_eno", get_eno(sel), 0);
            chk("rx_out", get_out(sel), 0);
`ifdef SIMPLEADDER_SERIAL_BUSYERR_EN
            chk("rx_busy", get_busy(sel), exp_busy);
`endif
            e = (k == 0) || (k == stb);
            exp_busy = (k != 0) && (k == stb);
            drive(sel, e, a[w-1-k], b[w-1-k]);
        end
        for (int j = 0; j <= w; j++) begin
            @(negedge clk);
            chk("tx_eno", get_eno(sel), 1);
            chk("tx_out", get_out(sel), (s >> (w - j)) & 1);
`ifdef SIMPLEADDER_SERIAL_BUSYERR_EN
            chk("tx_busy", get_busy(sel), exp_busy);
`endif
            e = ((w + j) == stb);
            exp_busy = e;
            drive(sel, e, 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        int sel, w, a, b, stb;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_eno2", eno2, 0);
        chk("rst_out2", out2, 0);
        chk("rst_eno4", eno4, 0);
        chk("rst_out4", out4, 0);
`ifdef SIMPLEADDER_SERIAL_BUSYERR_EN
        chk("rst_busy2", busy2, 0);
        chk("rst_busy4", busy4, 0);
`endif
        rst_n = 1'b1;
        idle(2);

        frame(0, 2, 3, 2, -1);
        frame(0, 2, 3, 3, -1);
        frame(0, 2, 0, 0, -1);
        frame(0, 2, 2, 1, 1);
        frame(0, 2, 1, 1, 2);
        frame(0, 2, 3, 1, 3);
        idle(1);
        frame(1, 4, 15, 1, -1);
        frame(1, 4, 15, 15, 5);
        frame(1, 4, 9, 7, 2);
        idle(2);

        // Asynchronous reset while the first sum bit (1) is on out
        @(negedge clk); drive(0, 1'b1, 1'b1, 1'b1);
        @(negedge clk); drive(0, 1'b0, 1'b1, 1'b0);
        @(negedge clk); drive(0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_eno", eno2, 1);
        chk("pre_rst_out", out2, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_eno", eno2, 0);
        chk("async_rst_out", out2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        frame(0, 2, 1, 2, -1);
        idle(1);

        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 1));
            w = (sel == 0) ? 2 : 4;
            a = int'($urandom_range(0, (1 << w) - 1));
            b = int'($urandom_range(0, (1 << w) - 1));
            stb = ($urandom_range(0, 1) == 1) ?
                  int'($urandom_range(1, 2 * w - 1)) : -1;
            frame(sel, w, a, b, stb);
            idle(int'($urandom_range(0, 2)));
        end

        idle(1);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/simpleadder_serial.md
Name: simpleadder_serial

Overview:
- Bit-serial unsigned adder.
- Receives two WIDTH-bit operands on single-bit lines ina/inb, MSB first, framed by a one-cycle start strobe en_i.
- Returns the (WIDTH+1)-bit sum MSB first on out, framed by en_o.
- Leaf datapath block between a serial stimulus source and a serial consumer.

Parameters:
- WIDTH, 2, operand width in bits (>=1); result width is WIDTH+1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- ina  input  1  operand A serial bit, MSB first
- inb  input  1  operand B serial bit, MSB first
- en_i  input  1  start strobe; high in the cycle carrying the operand MSBs
- out  output  1  result serial bit, MSB first; 0 when not sending
- en_o  output  1  high for every cycle a valid result bit is on out

Behaviour:
- One clock (clk) and one reset (rst_n); reset is asynchronous and active-low.
- Reset values: out=0, en_o=0, state=IDLE, shift registers and counters cleared. Reset mid-frame aborts the frame with no partial output.
- States: IDLE, RECV, SEND.
- IDLE:
  - On a posedge with en_i=1, capture ina/inb as the operand MSBs and go to RECV with bit counter = WIDTH-1.
  - en_i=0 keeps the block in IDLE.
- RECV:
  - Each posedge captures the next ina/inb bit, MSB first, regardless of en_i.
  - After the LSB is captured, compute sum = A + B (unsigned, WIDTH+1 bits, no truncation) and load it into the output shift register.
  - The same edge drives out = sum MSB and en_o = 1, then the block enters SEND.
- Latency: first result bit is visible the cycle after the operand-LSB sampling edge, i.e. WIDTH cycles after the en_i sampling edge.
- SEND:
  - Each posedge shifts out the next result bit, WIDTH+1 bits total, with en_o held high throughout.
  - After the last bit's cycle, drive out=0 and en_o=0 and return to IDLE.
  - en_i can be accepted on that same edge: a new frame may start in the cycle after the last result bit.
- en_i asserted during RECV or SEND is ignored; it does not restart or corrupt the current frame.
- Outputs are registered only; no combinational path from inputs to outputs.
- Wrap-around: all-ones operands produce carry-out as the result MSB (e.g. WIDTH=2: 3+3=6 -> 110).

Optional Feature:
- Macro SIMPLEADDER_SERIAL_BUSYERR_EN.
- Defined:
  - Adds output busy_err (1 bit, reset 0).
  - busy_err pulses high for exactly one cycle, the cycle after any posedge where en_i=1 is sampled while state is RECV or SEND.
  - The frame in progress is unaffected.
- Undefined: port busy_err does not exist; en_i during a frame is silently ignored.

Decomposition:
- Package simpleadder_serial_pkg holds:
  - the state enum (IDLE, RECV, SEND)
  - default WIDTH constant
  - localparam function for result width (WIDTH+1)
  - counter width derived via $clog2(WIDTH+1)
- One natural sub-module, serial_shift_reg: a parameterized load/shift register with serial-in and serial-out modes. It is instantiated twice for operand capture and once for result output.
- FSM and adder stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-SEND -> out=0 and en_o=0 immediately (asynchronously); next en_i frame produces a correct result.
- Basic, WIDTH=2: en_i=1 with ina/inb MSB=1/1, then LSB=1/0 (A=3, B=2) -> en_o high 3 cycles, out=1,0,1 (5), first bit WIDTH cycles after the en_i sampling edge.
- Carry: A=3, B=3 -> out=1,1,0; A=0, B=0 -> en_o high 3 cycles with out=0,0,0.
- Back-to-back: a new en_i in the cycle after the last result bit -> second frame accepted; result correct with no idle gap required.
- Ignored strobe: en_i=1 during RECV and during SEND -> current result unchanged, no new frame. With SIMPLEADDER_SERIAL_BUSYERR_EN, busy_err pulses one cycle per occurrence.
- Parameter sweep: WIDTH=4, A=15, B=1 -> out=1,0,0,0,0 over 5 cycles with en_o high for all 5.
